// File: rtl/present_sbox_layer_ctrl.sv
// Sequences a 3-share 64-bit state through one shared, pipelined masked S-box, nibble by nibble.
// Optional macro SBOX_CTRL_IDLE_ZERO_EN forces the S-box inputs to 0 in non-issue cycles.
module present_sbox_layer_ctrl #(
    parameter int unsigned SBOX_LAT = 3,
    parameter int unsigned NIBBLES  = 16
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [4*NIBBLES-1:0] state1_i,
    input  logic [4*NIBBLES-1:0] state2_i,
    input  logic [4*NIBBLES-1:0] state3_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [4*NIBBLES-1:0] state1_o,
    output logic [4*NIBBLES-1:0] state2_o,
    output logic [4*NIBBLES-1:0] state3_o,
    input  logic [52:0]          rand_i,
    input  logic                 rand_valid_i,
    output logic                 rand_ready_o,
    output logic [3:0]           sbox_in1_o,
    output logic [3:0]           sbox_in2_o,
    output logic [3:0]           sbox_in3_o,
    output logic [44:0]          sbox_r_o,
    output logic [7:0]           sbox_rs_in_o,
    input  logic [7:0]           sbox_rs_out_i,
    input  logic [3:0]           sbox_out1_i,
    input  logic [3:0]           sbox_out2_i,
    input  logic [3:0]           sbox_out3_i
);
    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned CntW = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [W-1:0]        sh1_q, sh1_d, sh2_q, sh2_d, sh3_q, sh3_d;
    logic [W-1:0]        res1_q, res1_d, res2_q, res2_d, res3_q, res3_d;
    logic [CntW-1:0]     issue_cnt_q, issue_cnt_d, cap_cnt_q, cap_cnt_d;
    logic [SBOX_LAT-1:0] vpipe_q, vpipe_d;
    logic                prev_issue_q;
    logic                issue, tap;

    assign issue = (state_q == StIssue) && rand_valid_i;
    assign tap   = vpipe_q[SBOX_LAT-1];

    always_comb begin
        state_d     = state_q;
        sh1_d       = sh1_q;
        sh2_d       = sh2_q;
        sh3_d       = sh3_q;
        res1_d      = res1_q;
        res2_d      = res2_q;
        res3_d      = res3_q;
        issue_cnt_d = issue_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        vpipe_d     = (vpipe_q << 1) | SBOX_LAT'(issue);

        // Only tapped (issued) slots are written; bubbles never reach the result.
        if (tap) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (cap_cnt_q == CntW'(i)) begin
                    res1_d[4*i +: 4] = sbox_out1_i;
                    res2_d[4*i +: 4] = sbox_out2_i;
                    res3_d[4*i +: 4] = sbox_out3_i;
                end
            end
            cap_cnt_d = cap_cnt_q + CntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    sh1_d       = state1_i;
                    sh2_d       = state2_i;
                    sh3_d       = state3_i;
                    issue_cnt_d = '0;
                    cap_cnt_d   = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (issue) begin
                    sh1_d       = sh1_q >> 4;
                    sh2_d       = sh2_q >> 4;
                    sh3_d       = sh3_q >> 4;
                    issue_cnt_d = issue_cnt_q + CntW'(1);
                    if (issue_cnt_q == CntW'(NIBBLES - 1)) state_d = StDrain;
                end
            end
            StDrain: begin
                // Leave on the final capture so done_o lands the cycle after it.
                if (tap && cap_cnt_q == CntW'(NIBBLES - 1)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o       = (state_q == StIssue) || (state_q == StDrain);
        done_o       = (state_q == StDone);
        rand_ready_o = issue;
        state1_o     = res1_q;
        state2_o     = res2_q;
        state3_o     = res3_q;
`ifdef SBOX_CTRL_IDLE_ZERO_EN
        sbox_in1_o   = issue ? sh1_q[3:0] : 4'h0;
        sbox_in2_o   = issue ? sh2_q[3:0] : 4'h0;
        sbox_in3_o   = issue ? sh3_q[3:0] : 4'h0;
        sbox_r_o     = issue ? rand_i[44:0] : 45'h0;
        sbox_rs_in_o = issue ? (prev_issue_q ? sbox_rs_out_i : rand_i[52:45]) : 8'h0;
`else
        sbox_in1_o   = sh1_q[3:0];
        sbox_in2_o   = sh2_q[3:0];
        sbox_in3_o   = sh3_q[3:0];
        sbox_r_o     = rand_i[44:0];
        sbox_rs_in_o = prev_issue_q ? sbox_rs_out_i : rand_i[52:45];
`endif
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            sh1_q        <= '0;
            sh2_q        <= '0;
            sh3_q        <= '0;
            res1_q       <= '0;
            res2_q       <= '0;
            res3_q       <= '0;
            issue_cnt_q  <= '0;
            cap_cnt_q    <= '0;
            vpipe_q      <= '0;
            prev_issue_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh1_q        <= sh1_d;
            sh2_q        <= sh2_d;
            sh3_q        <= sh3_d;
            res1_q       <= res1_d;
            res2_q       <= res2_d;
            res3_q       <= res3_d;
            issue_cnt_q  <= issue_cnt_d;
            cap_cnt_q    <= cap_cnt_d;
            vpipe_q      <= vpipe_d;
            prev_issue_q <= issue;
        end
    end
endmodule

// File: tb/tb_present_sbox_layer_ctrl.sv
// Bench for present_sbox_layer_ctrl: models a masked pipelined PRESENT S-box and scoreboards layers.
module tb_present_sbox_layer_ctrl;
    localparam int unsigned L = 3;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [63:0] state1_i, state2_i, state3_i;
    logic        busy_o, done_o;
    logic [63:0] state1_o, state2_o, state3_o;
    logic [52:0] rand_i;
    logic        rand_valid_i, rand_ready_o;
    logic [3:0]  sbox_in1_o, sbox_in2_o, sbox_in3_o;
    logic [44:0] sbox_r_o;
    logic [7:0]  sbox_rs_in_o, sbox_rs_out_i;
    logic [3:0]  sbox_out1_i, sbox_out2_i, sbox_out3_i;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    logic [3:0] pipe_x [L];
    logic [7:0] pipe_m [L];
    logic [7:0] pipe_rs [L];

    always #5 clk = ~clk;

    present_sbox_layer_ctrl #(.SBOX_LAT(L), .NIBBLES(16)) dut (
        .clk(clk), .rst_i(rst_i), .start_i(start_i),
        .state1_i(state1_i), .state2_i(state2_i), .state3_i(state3_i),
        .busy_o(busy_o), .done_o(done_o),
        .state1_o(state1_o), .state2_o(state2_o), .state3_o(state3_o),
        .rand_i(rand_i), .rand_valid_i(rand_valid_i), .rand_ready_o(rand_ready_o),
        .sbox_in1_o(sbox_in1_o), .sbox_in2_o(sbox_in2_o), .sbox_in3_o(sbox_in3_o),
        .sbox_r_o(sbox_r_o), .sbox_rs_in_o(sbox_rs_in_o), .sbox_rs_out_i(sbox_rs_out_i),
        .sbox_out1_i(sbox_out1_i), .sbox_out2_i(sbox_out2_i), .sbox_out3_i(sbox_out3_i)
    );

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC; 4'h1: sbox = 4'h5; 4'h2: sbox = 4'h6; 4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9; 4'h5: sbox = 4'h0; 4'h6: sbox = 4'hA; 4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3; 4'h9: sbox = 4'hE; 4'hA: sbox = 4'hF; 4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4; 4'hD: sbox = 4'h7; 4'hE: sbox = 4'h1; default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox(x[4*i +: 4]);
        return y;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Masked S-box model: output shares {S(x)^m0^m1, m0, m1}, rs_out derived from rs_in and r.
    always @(posedge clk) begin
        pipe_x[0]  <= sbox_in1_o ^ sbox_in2_o ^ sbox_in3_o;
        pipe_m[0]  <= sbox_r_o[7:0];
        pipe_rs[0] <= sbox_rs_in_o ^ sbox_r_o[15:8];
        for (int i = 1; i < L; i++) begin
            pipe_x[i]  <= pipe_x[i-1];
            pipe_m[i]  <= pipe_m[i-1];
            pipe_rs[i] <= pipe_rs[i-1];
        end
    end
    assign sbox_out1_i   = sbox(pipe_x[L-1]) ^ pipe_m[L-1][3:0] ^ pipe_m[L-1][7:4];
    assign sbox_out2_i   = pipe_m[L-1][3:0];
    assign sbox_out3_i   = pipe_m[L-1][7:4];
    assign sbox_rs_out_i = pipe_rs[0];

    always @(negedge clk) begin
        if (done_o) begin
            check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) check_eq("result", state1_o ^ state2_o ^ state3_o, sb_q.pop_front());
        end
    end

    function automatic logic [52:0] rnd53();
        return {$urandom_range(0, 2**21 - 1), $urandom(), $urandom()} ;
    endfunction

    // mode 0: rand always valid, 1: random valid, 2: invalid in cycles 3, 4, 10
    function automatic logic valid_for(input int cyc, input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 2) return !(cyc == 3 || cyc == 4 || cyc == 10);
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic run_layer(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                             input int mode);
        int done_cyc, rdy_cnt, busy_cnt, issued, bubbles;
        done_cyc = -1; rdy_cnt = 0; busy_cnt = 0; issued = 0; bubbles = 0;
        sb_q.push_back(sbox_layer(a ^ b ^ c));
        @(posedge clk); #1;
        start_i = 1'b1; state1_i = a; state2_i = b; state3_i = c;
        rand_i = rnd53(); rand_valid_i = 1'b0;
        for (int cyc = 0; cyc < 300 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (rand_ready_o) rdy_cnt++;
            if (busy_o) busy_cnt++;
            if (done_o) done_cyc = cyc;
            if (mode == 0 && cyc == 1) begin
                check_eq("in1_first", 64'(sbox_in1_o), 64'(a[3:0]));
                check_eq("r_first", 64'(sbox_r_o), 64'(rand_i[44:0]));
            end
            if (mode == 0 && cyc == 2) check_eq("in2_second", 64'(sbox_in2_o), 64'(b[7:4]));
            if (mode == 2 && cyc == 2) check_eq("rs_chain", 64'(sbox_rs_in_o), 64'(sbox_rs_out_i));
            if (mode == 2 && cyc == 5) check_eq("rs_fresh", 64'(sbox_rs_in_o), 64'(rand_i[52:45]));
            if (done_cyc < 0) begin
                @(posedge clk); #1;
                start_i = 1'b0;
                rand_i = rnd53();
                rand_valid_i = valid_for(cyc + 1, mode);
                if (issued < 16) begin
                    if (rand_valid_i) issued++;
                    else bubbles++;
                end
            end
        end
        start_i = 1'b0;
        check_eq("done_cycle", 64'(done_cyc), 64'(17 + L + bubbles));
        check_eq("ready_count", 64'(rdy_cnt), 64'd16);
        check_eq("busy_count", 64'(busy_cnt), 64'(16 + L + bubbles));
    endtask

    initial begin
        int d1, d2;
        logic [63:0] a, b, c;
        rst_i = 1'b1; start_i = 1'b0; rand_valid_i = 1'b0; rand_i = '0;
        state1_i = '0; state2_i = '0; state3_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_done", 64'(done_o), 64'd0);
        check_eq("rst_ready", 64'(rand_ready_o), 64'd0);
        check_eq("rst_out", state1_o | state2_o | state3_o, 64'd0);
        check_eq("rst_sbox_in", 64'({sbox_in1_o, sbox_in2_o, sbox_in3_o}), 64'd0);
        rst_i = 1'b0;

        // Unshared known-answer layer
        sb_q.push_back(64'hC56B90AD3EF84712);
        sb_q.pop_back();
        run_layer(64'h0123456789ABCDEF, 64'h0, 64'h0, 0);
        check_eq("kat_value", state1_o ^ state2_o ^ state3_o, 64'hC56B90AD3EF84712);

        run_layer({$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 2);

        // Reset mid-layer, then a clean layer must not pick up stale captures
        @(posedge clk); #1;
        start_i = 1'b1; state1_i = {$urandom(), $urandom()}; state2_i = '1; state3_i = '0;
        rand_valid_i = 1'b1; rand_i = rnd53();
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rand_i = '0;
        rst_i = 1'b1;
        #1;
        check_eq("mid_rst_busy", 64'(busy_o), 64'd0);
        check_eq("mid_rst_ready", 64'(rand_ready_o), 64'd0);
        check_eq("mid_rst_out", state1_o | state2_o | state3_o, 64'd0);
        check_eq("mid_rst_sbox_in", 64'({sbox_in1_o, sbox_in2_o, sbox_in3_o}), 64'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        run_layer({$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 0);

        // start_i held high: second layer only after DONE
        a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()}; c = {$urandom(), $urandom()};
        sb_q.push_back(sbox_layer(a ^ b ^ c));
        sb_q.push_back(sbox_layer(a ^ b ^ c));
        d1 = -1; d2 = -1;
        @(posedge clk); #1;
        start_i = 1'b1; state1_i = a; state2_i = b; state3_i = c;
        rand_valid_i = 1'b1; rand_i = rnd53();
        for (int cyc = 0; cyc < 120 && d2 < 0; cyc++) begin
            @(negedge clk);
            if (done_o) begin
                if (d1 < 0) d1 = cyc;
                else d2 = cyc;
            end
            @(posedge clk); #1;
            rand_i = rnd53();
        end
        start_i = 1'b0;
        check_eq("held_done1", 64'(d1), 64'(17 + L));
        check_eq("held_done2", 64'(d2), 64'(2 * (17 + L) + 1));

        for (int n = 0; n < 1000; n++)
            run_layer({$urandom(), $urandom()}, {$urandom(), $urandom()},
                      {$urandom(), $urandom()}, 1);

        repeat (2) @(posedge clk);
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
